// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory fetch controller:
// FSM state encodings and default geometry / reset PC.
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } fetch_state_e;

    localparam int DEF_ADDR_W   = 6;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/imem_next_pc.sv
// Next-PC selection for the fetch controller: stall holds, then jump, then
// branch, otherwise sequential increment wrapping at the top of memory.
module imem_next_pc #(
    parameter int ADDR_W = 6
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] next_pc
);

    // Priority mux; the increment wraps naturally in ADDR_W bits
    always_comb begin
        next_pc = pc;
        if (stall) begin
            next_pc = pc;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the single-cycle core: owns PC, instruction memory
// port, and a valid/ready program-load path used while the core is idle.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              halt,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [1:0]        state_o
);

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PTR_MAX    = '1;

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              done_r;
    logic              done_nxt_s;
    logic [ADDR_W-1:0] next_pc_s;

    imem_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc            (pc_r),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc_s)
    );

    // Next-state and memory/core-facing outputs
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        load_ready  = 1'b0;
        imem_addr   = pc_r;
        imem_we     = 1'b0;
        imem_wdata  = '0;
        instr       = '0;
        instr_valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_start) begin
                    state_nxt_s = ST_LOAD;
                end else if (run_en) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                imem_addr  = ptr_r;
                if (load_valid) begin
                    imem_we    = 1'b1;
                    imem_wdata = load_data;
                    // Last word, or memory full: finish the image
                    if (load_last || (ptr_r == PTR_MAX)) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                instr       = imem_rdata;
                instr_valid = 1'b1;
                if (halt) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, PC, load pointer and done pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC_V;
            ptr_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= done_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (load_start) begin
                        ptr_r <= '0;
                    end else if (run_en) begin
                        pc_r <= RESET_PC_V;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        ptr_r <= ptr_r + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!halt) begin
                        pc_r <= next_pc_s;
                    end
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign load_done = done_r;
    assign pc        = pc_r;
    assign state_o   = state_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: expected memory writes and fetches are
// queued by the stimulus and consumed by a negedge monitor.
module tb_imem_fetch_ctrl;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        run_en, halt, load_start, load_valid, load_last;
    logic [31:0] load_data;
    logic        load_ready, load_done;
    logic        stall, jump, branch_taken;
    logic [5:0]  jump_target, branch_target;
    logic [5:0]  imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata, imem_rdata;
    logic [5:0]  pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [1:0]  state_o;

    logic [31:0] mem [64];
    txn_t        exp_wr [$];
    txn_t        exp_fe [$];
    int          total = 0;
    int          bad   = 0;
    int          done_cnt = 0;

    imem_fetch_ctrl dut (
        .clk(clk), .rst(rst), .run_en(run_en), .halt(halt),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .stall(stall), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
        .imem_rdata(imem_rdata), .pc(pc), .instr(instr),
        .instr_valid(instr_valid), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];
    always @(posedge clk) if (imem_we === 1'b1) mem[imem_addr] <= imem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT writes or presents a fetch
    always @(negedge clk) begin
        txn_t t;
        if (load_done === 1'b1) done_cnt++;
        if (imem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write", {26'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                t = exp_wr.pop_front();
                chk("wr_addr", {26'd0, imem_addr}, {26'd0, t.addr});
                chk("wr_data", imem_wdata, t.data);
            end
        end
        if (instr_valid === 1'b1) begin
            if (exp_fe.size() == 0) begin
                chk("unexpected_fetch", {26'd0, pc}, 32'hFFFF_FFFF);
            end else begin
                t = exp_fe.pop_front();
                chk("fe_pc", {26'd0, pc}, {26'd0, t.addr});
                chk("fe_instr", instr, t.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
        txn_t t;
        t.addr = a;
        t.data = d;
        exp_wr.push_back(t);
    endtask

    task automatic push_fe(input logic [5:0] a, input logic [31:0] d);
        txn_t t;
        t.addr = a;
        t.data = d;
        exp_fe.push_back(t);
    endtask

    // Load vectors: valid, data, last, expected write address
    logic        lv_valid [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] lv_data  [7] = '{32'h2008_0005, 32'hDEAD_BEEF, 32'h2009_0003,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0109_5020,
                                  32'h0800_0000};
    logic        lv_last  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [5:0]  lv_addr  [7] = '{6'd0, 6'd0, 6'd1, 6'd0, 6'd0, 6'd2, 6'd3};

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
        rst = 1'b1; run_en = 1'b0; halt = 1'b0; load_start = 1'b0;
        load_valid = 1'b0; load_data = 32'd0; load_last = 1'b0;
        stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = 6'd0; branch_target = 6'd0;

        // Reset
        step(); step();
        rst = 1'b0;
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_pc", {26'd0, pc}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);

        // Load with gaps; load_last on invalid cycles must be ignored
        load_start = 1'b1; run_en = 1'b1;
        step();
        load_start = 1'b0; run_en = 1'b0;
        chk("load_state", {30'd0, state_o}, 32'd1);
        chk("load_ready", {31'd0, load_ready}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            load_valid = lv_valid[i];
            load_data  = lv_data[i];
            load_last  = lv_last[i];
            if (lv_valid[i]) push_wr(lv_addr[i], lv_data[i]);
            step();
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("load_end_state", {30'd0, state_o}, 32'd0);
        chk("load_done_pulse", {31'd0, load_done}, 32'd1);
        step();
        chk("load_done_clear", {31'd0, load_done}, 32'd0);
        chk("done_cnt_1", done_cnt, 32'd1);
        chk("mem4_untouched", mem[4], 32'hA500_0004);

        // Run sequentially 0..4
        run_en = 1'b1;
        step();
        run_en = 1'b0;
        push_fe(6'd0, 32'h2008_0005); step();
        push_fe(6'd1, 32'h2009_0003); step();
        push_fe(6'd2, 32'h0109_5020); step();
        push_fe(6'd3, 32'h0800_0000); step();
        // Jump beats branch
        push_fe(6'd4, 32'hA500_0004);
        jump = 1'b1; jump_target = 6'h10; branch_taken = 1'b1; branch_target = 6'h20;
        step();
        // Stall beats jump
        push_fe(6'h10, 32'hA500_0010);
        stall = 1'b1; jump = 1'b1; jump_target = 6'h05; branch_taken = 1'b0;
        step();
        push_fe(6'h10, 32'hA500_0010);
        stall = 1'b0; jump = 1'b0; branch_taken = 1'b1; branch_target = 6'h20;
        step();
        push_fe(6'h20, 32'hA500_0020);
        branch_taken = 1'b0; jump = 1'b1; jump_target = 6'h3F;
        step();
        // Wrap 63 -> 0
        push_fe(6'h3F, 32'hA500_003F);
        jump = 1'b0;
        step();
        push_fe(6'd0, 32'h2008_0005);
        step();
        // Halt beats jump; PC retained
        push_fe(6'd1, 32'h2009_0003);
        halt = 1'b1; jump = 1'b1; jump_target = 6'd5;
        step();
        halt = 1'b0; jump = 1'b0;
        chk("halt_state", {30'd0, state_o}, 32'd0);
        chk("halt_pc", {26'd0, pc}, 32'd1);
        chk("idle_instr", instr, 32'd0);
        // Re-entering RUN reloads RESET_PC
        run_en = 1'b1;
        step();
        run_en = 1'b0;
        push_fe(6'd0, 32'h2008_0005);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("rerun_pc", {26'd0, pc}, 32'd0);

        // Full 64-word load without load_last
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hC000_0000 | i;
            push_wr(i[5:0], 32'hC000_0000 | i);
            step();
        end
        load_valid = 1'b0;
        chk("full_state", {30'd0, state_o}, 32'd0);
        chk("full_done", {31'd0, load_done}, 32'd1);
        step();
        chk("done_cnt_2", done_cnt, 32'd2);

        // Reset mid-load after two words
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 32'h1111_0000; push_wr(6'd0, 32'h1111_0000); step();
        load_data = 32'h1111_0001; push_wr(6'd1, 32'h1111_0001); step();
        load_valid = 1'b0; load_data = 32'h1111_0002;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_state", {30'd0, state_o}, 32'd0);
        chk("midrst_ready", {31'd0, load_ready}, 32'd0);
        chk("midrst_done", {31'd0, load_done}, 32'd0);
        step(); step();
        chk("done_cnt_3", done_cnt, 32'd2);
        chk("mem0", mem[0], 32'h1111_0000);
        chk("mem1", mem[1], 32'h1111_0001);
        chk("mem2", mem[2], 32'hC000_0002);

        chk("wr_queue_empty", exp_wr.size(), 32'd0);
        chk("fe_queue_empty", exp_fe.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequencer that owns the single-cycle core's 64x32 instruction memory.
- Holds the program counter and drives the memory address.
- Supplies the fetched instruction to the core and applies jump/branch redirects and stalls.
- Provides a load mode that streams a program image into the memory through a valid/ready port while the core is held idle.
- Sits between the instruction memory and the control/datapath of the MIPS core.

Parameters:
ADDR_W, 6, word address width (memory depth 2^ADDR_W)
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset and on each RUN entry

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
run_en  in  1  IDLE->RUN request
halt  in  1  RUN->IDLE request
load_start  in  1  IDLE->LOAD request
load_valid  in  1  load word present
load_data  in  DATA_W  load word
load_last  in  1  qualifies final load word
load_ready  out  1  controller accepts load word
load_done  out  1  one-cycle pulse at end of load
stall  in  1  hold PC (core hazard/wait)
jump  in  1  redirect to jump_target
jump_target  in  ADDR_W  jump word address
branch_taken  in  1  redirect to branch_target
branch_target  in  ADDR_W  branch word address
imem_addr  out  ADDR_W  memory address (PC or load pointer)
imem_we  out  1  memory write strobe
imem_wdata  out  DATA_W  memory write data
imem_rdata  in  DATA_W  memory combinational read data
pc  out  ADDR_W  current PC
instr  out  DATA_W  fetched instruction
instr_valid  out  1  instr is valid this cycle
state_o  out  2  current FSM state (debug)

Behaviour:
- States: IDLE=0, LOAD=1, RUN=2. Reset forces IDLE.
- Reset values: pc=RESET_PC, load pointer=0, load_ready=0, load_done=0, imem_we=0, instr_valid=0, state_o=0.
- IDLE:
  - load_start -> LOAD; load pointer cleared to 0.
  - Otherwise run_en -> RUN; pc=RESET_PC.
  - load_start has priority over run_en when both are high.
- LOAD:
  - load_ready=1 combinationally.
  - A transfer occurs on a cycle with load_valid&&load_ready.
  - On transfer: imem_we=1, imem_addr=pointer, imem_wdata=load_data (same cycle); pointer increments modulo 2^ADDR_W.
  - Transfer with load_last, or transfer at pointer=2^ADDR_W-1: next state IDLE and load_done=1 for exactly the following cycle.
  - Without load_valid: no write and pointer holds.
  - run_en and halt are ignored.
- RUN:
  - imem_addr=pc; instr=imem_rdata (zero-latency combinational read); instr_valid=1.
  - Next-PC priority: stall (hold) > jump (jump_target) > branch_taken (branch_target) > pc+1.
  - pc+1 wraps 2^ADDR_W-1 -> 0.
  - halt -> IDLE next cycle; pc retains its value; halt beats every next-PC source.
- Outside RUN: instr_valid=0 and instr=0. imem_we is high only on LOAD transfers.
- Outside LOAD: imem_addr=pc and imem_wdata=0.
- rst asserted in any state, including mid-load: next cycle is IDLE with reset values. Words already written stay in memory; no load_done pulse.
- Targets are ADDR_W bits wide, so no range check is performed.

Decomposition:
- Shared package holds:
  - state encodings IDLE/LOAD/RUN
  - ADDR_W/DATA_W defaults
  - RESET_PC constant
- One natural sub-module, imem_next_pc: a purely combinational priority mux (stall/jump/branch/increment with wrap).
- FSM, PC register and load pointer remain in the top module.

Test Plan:
- Reset: rst high 2 cycles, then low -> state_o=0, pc=0, instr_valid=0, load_ready=0, imem_we=0.
- Load: load_start, then 4 words 0x20080005, 0x20090003, 0x01095020, 0x08000000 (last on 4th) with load_valid gaps -> writes to addr 0..3 only on valid cycles; load_done pulses once; state returns to IDLE.
- Run: run_en with memory from previous scenario -> pc 0,1,2,3,4 on successive cycles; instr=0x20080005 at pc 0; instr_valid=1.
- Redirect: jump=1 with target 0x10 and branch_taken=1 with target 0x20 in the same cycle -> pc=0x10. Then stall+jump -> pc holds. Then branch only -> 0x20.
- Wrap: pc=63, no redirect -> next pc=0. Full 64-word load without load_last -> load_done after word 63.
- Reset mid-load after 2 of 5 words -> IDLE next cycle, no load_done; mem[0..1] updated, mem[2] unchanged.
